// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the priority encoder slice.
// OUT_W is derived here so the core and the top always agree on index width.
package pri_enc_pkg;

  localparam int PRI_ENC_DEFAULT_WIDTH = 8;

  // Ceiling log2, never below 1, so a 1-bit index port stays legal.
  function automatic int clog2_safe(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pri_encoder_core.sv
// Purely combinational priority encoder: index of the highest set bit of in.
// any_set flags a non-empty request vector; out is 0 when nothing is set.
module pri_encoder_core
  import pri_enc_pkg::*;
#(
  parameter int WIDTH = PRI_ENC_DEFAULT_WIDTH,
  localparam int OUT_W = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             any_set
);

  logic found;

  // Walk from the MSB down; the first hit wins and locks out lower bits.
  always_comb begin
    out   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i] && !found) begin
        out   = i[OUT_W-1:0];
        found = 1'b1;
      end
    end
    any_set = found;
  end

endmodule

// File: rtl/priority_encoder_8x3.sv
// Registered priority encoder: one clock of latency from in to {valid, out}.
// Outputs come straight from flops; there is no combinational path from in.
module priority_encoder_8x3
  import pri_enc_pkg::*;
#(
  parameter int WIDTH = PRI_ENC_DEFAULT_WIDTH,
  localparam int OUT_W = clog2_safe(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] core_out;
  logic             core_any;

  pri_encoder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in      (in),
    .out     (core_out),
    .any_set (core_any)
  );

  // Valid semantics: no handshake; a result is produced every cycle. valid
  // qualifies out for the in sampled at the previous edge (out = 0 is
  // ambiguous without it), and reset discards that cycle's in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      out   <= '0;
    end else begin
      valid <= core_any;
      out   <= core_out;
    end
  end

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Bench for priority_encoder_8x3: directed vectors plus a 256-value sweep,
// checked through an expected-response queue by an independent monitor.
module tb_priority_encoder_8x3;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       valid;
  logic [2:0] out;

  logic [15:0] in16;
  logic        valid16;
  logic [3:0]  out16;

  logic        drv_active;
  logic        armed;

  logic [3:0]  exp_q[$];
  string       name_q[$];

  int          n_checks;
  int          n_fail;

  priority_encoder_8x3 u_dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .valid (valid),
    .out   (out)
  );

  priority_encoder_8x3 #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .in    (in16),
    .valid (valid16),
    .out   (out16)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst        = 1'b1;
    in         = 8'h00;
    in16       = 16'h0000;
    drv_active = 1'b0;
  end

  // Reference model: scan upward, last set bit seen is the MSB.
  function automatic logic [3:0] model(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
    return {|v, idx};
  endfunction

  // Driver: presents one vector just after an edge and queues its expectation.
  task automatic drive(input logic [7:0] v, input logic r,
                       input logic [3:0] exp, input string name);
    @(posedge clk);
    #1;
    in         = v;
    rst        = r;
    drv_active = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    drv_active = 1'b0;
  endtask

  // Monitor: an armed edge means the DUT captured a driven vector.
  always @(posedge clk) armed <= drv_active;

  always @(negedge clk) begin
    logic [3:0] e;
    string      nm;
    if (armed === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got valid=%0b out=%0d, queue empty", valid, out);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({valid, out} !== e) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                   nm, valid, out, e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] sweep_v [8];
    logic [2:0] sweep_o [8];
    n_checks = 0;
    n_fail   = 0;
    sweep_v = '{8'b10000001, 8'b01010100, 8'b00101001, 8'b00010111,
                8'b00001001, 8'b00000101, 8'b00000010, 8'b00000001};
    sweep_o = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

    // Reset held two cycles with all requests high, then release
    drive(8'hFF, 1'b1, 4'b0_000, "reset_hold_0");
    drive(8'hFF, 1'b1, 4'b0_000, "reset_hold_1");
    drive(8'hFF, 1'b0, 4'b1_111, "reset_release");

    for (int i = 0; i < 8; i++)
      drive(sweep_v[i], 1'b0, {1'b1, sweep_o[i]}, $sformatf("sweep_%0d", i));

    drive(8'h00, 1'b0, 4'b0_000, "empty");
    drive(8'h01, 1'b0, 4'b1_000, "bit0_only");

    // Back-to-back tracking
    drive(8'h80, 1'b0, 4'b1_111, "b2b_80");
    drive(8'h01, 1'b0, 4'b1_000, "b2b_01");
    drive(8'h00, 1'b0, 4'b0_000, "b2b_00");
    drive(8'h40, 1'b0, 4'b1_110, "b2b_40");

    // Reset mid-stream
    drive(8'h20, 1'b0, 4'b1_101, "mid_pre");
    drive(8'h20, 1'b1, 4'b0_000, "mid_reset");
    drive(8'h20, 1'b0, 4'b1_101, "mid_post");

    for (int v = 0; v < 256; v++)
      drive(v[7:0], 1'b0, model(v[7:0]), $sformatf("exh_%02h", v[7:0]));
    idle();

    // Wide smoke vector
    @(posedge clk);
    #1;
    in16 = 16'h0400;
    @(posedge clk);
    #1;
    n_checks++;
    if ({valid16, out16} !== 5'b1_1010) begin
      n_fail++;
      $display("FAIL width16_smoke: got valid=%0b out=%0d, expected valid=1 out=10",
               valid16, out16);
    end

    // Bounded drain of the scoreboard
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder_8x3.md
Name: priority_encoder_8x3

Overview:
- Registered 8-to-3 priority encoder: reports the index of the highest-numbered asserted input bit, plus a valid flag when any bit is set.
- Used wherever a request vector must be reduced to a single winning index, for example in interrupt or request selection.
- Combinational priority logic feeds an output register, giving one clock of latency.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two and at least 2.
- OUT_W, $clog2(WIDTH) = 3, width of the encoded index. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  request vector; bit i set means request i is active.
- valid  output  1  registered; 1 when the sampled in had at least one bit set.
- out  output  OUT_W  registered; index of the highest set bit of the sampled in.

Behaviour:
- Priority: MSB wins. out = i, where i is the largest index with in[i] = 1; all lower bits are ignored.
- Registration: in is sampled on each rising clk edge. valid and out reflect that sample after the edge, so latency is 1 cycle.
- No enable and no handshake: a new result is produced every cycle.
- All-zero input: valid = 0 and out = 0. Consumers must qualify out with valid, because in = 8'b00000001 also yields out = 0, but with valid = 1.
- Reset: while rst is high at a rising edge, valid <= 0 and out <= 0, regardless of in.
- Reset mid-stream: the in value presented during the reset cycle is discarded. The first edge with rst low captures the current in.
- Outputs are driven only from flops, with no combinational path from in to the outputs.
- X/Z on in: no requirement; the bench drives only known values.
- Generic WIDTH: the same priority rule applies. The index is the binary encoding of the bit position, zero-extended to OUT_W.

Decomposition:
- Shared package pri_enc_pkg holds the constant PRI_ENC_DEFAULT_WIDTH = 8 and a function clog2_safe used for OUT_W.
- Sub-module pri_encoder_core is a purely combinational priority encoder with ports in[WIDTH], out[OUT_W], any_set.
  - It is implemented as a descending loop or a tree of 2:1 priority merges.
- The top level instantiates pri_encoder_core and registers out and any_set into out and valid under clk/rst.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in = 8'hFF -> valid = 0, out = 3'b000 after each edge. Release rst -> next edge gives valid = 1, out = 3'b111.
- Priority sweep, one vector per cycle, each checked one cycle later with valid = 1:
  - 8'b10000001 -> out 111
  - 8'b01010100 -> out 110
  - 8'b00101001 -> out 101
  - 8'b00010111 -> out 100
  - 8'b00001001 -> out 011
  - 8'b00000101 -> out 010
  - 8'b00000010 -> out 001
  - 8'b00000001 -> out 000
- Empty input: in = 8'b00000000 -> valid = 0, out = 000. Then in = 8'b00000001 -> valid = 1, out = 000, which distinguishes the two cases.
- Latency and back-to-back: change in every cycle (8'h80, 8'h01, 8'h00, 8'h40). Outputs must track exactly one cycle behind: (1,111), (1,000), (0,000), (1,110). There must be no combinational change between edges.
- Reset mid-stream: with in = 8'h20 streaming, assert rst for one cycle -> that edge gives valid = 0, out = 0. The following edge gives valid = 1, out = 101.
- Exhaustive: all 256 values of in against a reference model -> out equals the MSB index, and valid equals the OR-reduction of in. Also run one WIDTH = 16 smoke vector: 16'h0400 -> out = 4'b1010.
